// File: rtl/ram_pkg.sv
// Shared constants and types for the 128x32 single-port RAM and its block readers.
// The widths here fix the RAM geometry and the longest burst a reader accepts.
package ram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 7;
    localparam int LEN_WIDTH  = 8;
    localparam int RAM_DEPTH  = 128;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [LEN_WIDTH-1:0]  len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2
    } rd_state_t;

    // Sequential address step; the carry out of the top bit is dropped so 127 wraps to 0.
    function automatic addr_t next_addr(input addr_t addr);
        return addr + addr_t'(1);
    endfunction

endpackage

// File: rtl/ram_rd_out_slot.sv
// Single-entry output register for the burst reader's valid/ready stream.
// Holds data and valid steady while the consumer stalls; slot_free says a new word may load.
module ram_rd_out_slot
    import ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  slot_free
);

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  handshake_s;

    // Slot can accept when empty or when its current word leaves this cycle.
    always_comb begin
        handshake_s = valid_r & out_ready;
        slot_free   = (~valid_r) | out_ready;
    end

    // Load takes priority over a plain drain so back-to-back beats keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            if (load) begin
                data_r  <= load_data;
                valid_r <= 1'b1;
            end else if (handshake_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read engine: walks the RAM's combinational read port from start_addr for len words
// and streams them over valid/ready. It only ever reads; the RAM writer owns we/d.
module ram_burst_reader
    import ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    rd_state_t             state_r;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  slot_free_s;
    logic                  load_s;
    logic                  accept_s;
    logic                  last_hs_s;
    logic                  out_valid_s;

    ram_rd_out_slot u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (ram_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid_s),
        .slot_free (slot_free_s)
    );

    // Decode the per-cycle events that move the FSM and counters.
    always_comb begin
        load_s    = 1'b0;
        accept_s  = 1'b0;
        last_hs_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (len != {LEN_WIDTH{1'b0}})) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            FETCH: begin
                load_s = slot_free_s;
            end
            LAST: begin
                if (out_valid_s && out_ready) begin
                    last_hs_s = 1'b1;
                end else begin
                    last_hs_s = 1'b0;
                end
            end
            default: begin
                load_s    = 1'b0;
                accept_s  = 1'b0;
                last_hs_s = 1'b0;
            end
        endcase
    end

    // Burst FSM with address and word counters; remaining is tested before it is decremented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_addr_r  <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {LEN_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cur_addr_r  <= start_addr;
                        remaining_r <= len;
                        busy_r      <= 1'b1;
                        state_r     <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (load_s) begin
                        cur_addr_r  <= next_addr(cur_addr_r);
                        remaining_r <= remaining_r - LEN_WIDTH'(1);
                        if (remaining_r == LEN_WIDTH'(1)) begin
                            state_r <= LAST;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= FETCH;
                    end
                end
                LAST: begin
                    if (last_hs_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= LAST;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ram_addr  = cur_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_s;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: table of bursts plus hand-built stall,
// start-while-busy and mid-burst reset sequences, all checked against a scoreboard queue.
module tb_ram_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  start_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [6:0]  ram_addr;
    logic [31:0] ram_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [31:0] mem [0:127];
    logic [31:0] sb[$];

    int total = 0;
    int bad = 0;
    int beats = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic [31:0] last_data = 32'h0;
    bit prev_stall = 1'b0;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  len;
        int          beats;
        logic [31:0] last;
        logic [6:0]  end_addr;
    } vec_t;
    vec_t vecs[6];

    ram_burst_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    assign ram_q = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every visible word must match the scoreboard head; handshakes pop it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) check("valid_hold", {31'b0, out_valid}, 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h expected no beat", out_data);
                end else begin
                    check("beat_data", out_data, sb[0]);
                end
                if (out_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    beats++;
                    last_data = out_data;
                    last_cyc = cyc;
                end
            end
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input logic [6:0] a, input logic [7:0] l, input bit push);
        logic [6:0] ad;
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = a;
        len = l;
        if (push) begin
            for (int i = 0; i < int'(l); i++) begin
                ad = a + i[6:0];
                sb.push_back(mem[ad]);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int first_cyc;
        bit pat[5];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[0] = '{7'd5,   8'd4,   4,   32'hA5000008, 7'd9};
        vecs[1] = '{7'd126, 8'd4,   4,   32'hA5000001, 7'd2};
        vecs[2] = '{7'd30,  8'd0,   0,   32'h0,        7'd0};
        vecs[3] = '{7'd127, 8'd1,   1,   32'hA500007F, 7'd0};
        vecs[4] = '{7'd0,   8'd255, 255, 32'hA500007E, 7'd127};
        vecs[5] = '{7'd100, 8'd128, 128, 32'hA5000063, 7'd100};
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5000000 + i;

        rst_n = 1'b0;
        start = 1'b0;
        start_addr = 7'd0;
        len = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", {25'b0, ram_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stall pattern 1,0,0,1,1 from the first valid cycle of a 3-word burst.
        b0 = beats; d0 = done_cnt;
        do_start(7'd10, 8'd3, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(20);
        repeat (2) @(negedge clk);
        check("stall_beats", beats - b0, 32'd3);
        check("stall_done", done_cnt - d0, 32'd1);
        check("stall_sb_empty", sb.size(), 32'd0);

        // A second start while a 10-word burst runs must be ignored.
        b0 = beats; d0 = done_cnt;
        do_start(7'd20, 8'd10, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; start_addr = 7'd50; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40);
        repeat (5) @(negedge clk);
        check("busy_start_beats", beats - b0, 32'd10);
        check("busy_start_done", done_cnt - d0, 32'd1);
        check("busy_start_sb", sb.size(), 32'd0);
        check("busy_start_idle", {31'b0, busy}, 32'd0);

        // Reset while the 3rd beat of an 8-word burst is on the bus.
        b0 = beats; d0 = done_cnt;
        do_start(7'd40, 8'd8, 1'b1);
        for (int c = 0; c < 20 && (beats - b0) < 2; c++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_beats", beats - b0, 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_addr", {25'b0, ram_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 32'd0);
        b0 = beats; d0 = done_cnt;
        do_start(7'd0, 8'd2, 1'b1);
        wait_done(20);
        repeat (2) @(negedge clk);
        check("post_rst_beats", beats - b0, 32'd2);
        check("post_rst_done", done_cnt - d0, 32'd1);
        check("post_rst_sb", sb.size(), 32'd0);

        // Table of bursts with out_ready held high.
        for (int v = 0; v < 6; v++) begin
            out_ready = 1'b1;
            b0 = beats; d0 = done_cnt;
            do_start(vecs[v].addr, vecs[v].len, 1'b1);
            if (vecs[v].beats > 0) begin
                @(negedge clk);
                check("lat_busy", {31'b0, busy}, 32'd1);
                check("lat_not_valid", {31'b0, out_valid}, 32'd0);
                @(negedge clk);
                check("lat_valid", {31'b0, out_valid}, 32'd1);
                first_cyc = cyc;
                wait_done(vecs[v].beats + 10);
                repeat (2) @(negedge clk);
                check("vec_beats", beats - b0, vecs[v].beats);
                check("vec_last", last_data, vecs[v].last);
                check("vec_rate", last_cyc - first_cyc, vecs[v].beats - 1);
                check("vec_done", done_cnt - d0, 32'd1);
                check("vec_busy", {31'b0, busy}, 32'd0);
                check("vec_end_addr", {25'b0, ram_addr}, {25'b0, vecs[v].end_addr});
                check("vec_sb", sb.size(), 32'd0);
            end else begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("len0_busy", {31'b0, busy}, 32'd0);
                    check("len0_valid", {31'b0, out_valid}, 32'd0);
                    check("len0_done", {31'b0, done}, 32'd0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
